// File: rtl/gray_pkg.sv
// Shared definitions for Gray code producers and consumers.
package gray_pkg;

   localparam int unsigned DEF_WIDTH = 3;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } state_t;

   // Gray to binary for codes up to 32 bits; bits at and above w are ignored.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
      logic [31:0] mask;
      logic [31:0] gm;
      logic [31:0] b;
      mask  = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      gm    = g & mask;
      b     = '0;
      b[31] = gm[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ gm[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray to binary converter, reusable by any Gray consumer.
module gray_to_bin
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   assign bin = WIDTH'(gray2bin(32'(gray), WIDTH));

endmodule

// File: rtl/gray_step_monitor.sv
// Samples an upstream Gray counter, classifies each step and counts wraps/errors.
module gray_step_monitor
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             locked,
   output logic             up,
   output logic             down,
   output logic             wrap,
   output logic             err,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   state_t           state;
   state_t           state_d;
   logic [WIDTH-1:0] nb;
   logic [WIDTH-1:0] bin_inc;
   logic [WIDTH-1:0] bin_dec;
   logic             is_hold;
   logic             is_up;
   logic             is_down;
   logic             is_err;

   logic [WIDTH-1:0] bin_d;
   logic             locked_d;
   logic             up_d;
   logic             down_d;
   logic             wrap_d;
   logic             err_d;
   logic [CNT_W-1:0] wrap_cnt_d;
   logic [CNT_W-1:0] err_cnt_d;

   gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
      .gray (gray),
      .bin  (nb)
   );

   // bin doubles as the reference; up is tested before down so WIDTH=1 resolves to up.
   assign bin_inc = bin + WIDTH'(1);
   assign bin_dec = bin - WIDTH'(1);
   assign is_hold = (nb == bin);
   assign is_up   = !is_hold && (nb == bin_inc);
   assign is_down = !is_hold && !is_up && (nb == bin_dec);
   assign is_err  = !is_hold && !is_up && !is_down;

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bin      <= '0;
         locked   <= 1'b0;
         up       <= 1'b0;
         down     <= 1'b0;
         wrap     <= 1'b0;
         err      <= 1'b0;
         wrap_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         state    <= state_d;
         bin      <= bin_d;
         locked   <= locked_d;
         up       <= up_d;
         down     <= down_d;
         wrap     <= wrap_d;
         err      <= err_d;
         wrap_cnt <= wrap_cnt_d;
         err_cnt  <= err_cnt_d;
      end
   end

   // Next-state: only accepted samples move the FSM.
   always_comb begin
      state_d = state;
      if (in) begin
         unique case (state)
            IDLE:    state_d = TRACK;
            TRACK:   state_d = is_err ? ERROR : TRACK;
            ERROR:   state_d = TRACK;
            default: state_d = IDLE;
         endcase
      end
   end

   // Next output values: load reference, classify step, update counters.
   always_comb begin
      bin_d      = bin;
      locked_d   = locked;
      up_d       = 1'b0;
      down_d     = 1'b0;
      wrap_d     = 1'b0;
      err_d      = 1'b0;
      wrap_cnt_d = wrap_cnt;
      err_cnt_d  = err_cnt;
      if (in) begin
         bin_d = nb;
         unique case (state)
            TRACK: begin
               if (is_up) begin
                  up_d = 1'b1;
                  if (bin == '1) begin
                     wrap_d     = 1'b1;
                     wrap_cnt_d = wrap_cnt + CNT_W'(1);
                  end
               end else if (is_down) begin
                  down_d = 1'b1;
               end else if (is_err) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  if (err_cnt != '1) begin
                     err_cnt_d = err_cnt + CNT_W'(1);
                  end
               end
            end
            default: locked_d = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed self-checking bench for gray_step_monitor (WIDTH=3, CNT_W=8).
module tb_gray_step_monitor;

   logic       clk;
   logic       reset;
   logic       in;
   logic [2:0] gray;
   logic [2:0] bin;
   logic       locked;
   logic       up;
   logic       down;
   logic       wrap;
   logic       err;
   logic [7:0] wrap_cnt;
   logic [7:0] err_cnt;

   int checks;
   int errors;

   gray_step_monitor #(.WIDTH(3), .CNT_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .gray     (gray),
      .bin      (bin),
      .locked   (locked),
      .up       (up),
      .down     (down),
      .wrap     (wrap),
      .err      (err),
      .wrap_cnt (wrap_cnt),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic step(input logic r, input logic en, input logic [2:0] g);
      reset = r;
      in    = en;
      gray  = g;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [2:0] e_bin, input logic e_lk,
                        input logic e_up, input logic e_dn, input logic e_wr, input logic e_er,
                        input logic [7:0] e_wc, input logic [7:0] e_ec);
      logic [23:0] obs;
      logic [23:0] exp;
      obs = {bin, locked, up, down, wrap, err, wrap_cnt, err_cnt};
      exp = {e_bin, e_lk, e_up, e_dn, e_wr, e_er, e_wc, e_ec};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed bin=%0d lk=%0b up=%0b dn=%0b wr=%0b er=%0b wc=%0d ec=%0d expected bin=%0d lk=%0b up=%0b dn=%0b wr=%0b er=%0b wc=%0d ec=%0d",
                tag, bin, locked, up, down, wrap, err, wrap_cnt, err_cnt,
                e_bin, e_lk, e_up, e_dn, e_wr, e_er, e_wc, e_ec);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      in     = 1'b0;
      gray   = 3'b000;

      // Reset state
      step(1'b1, 1'b1, 3'b101);
      step(1'b1, 1'b0, 3'b000);
      check("reset", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'd0);

      // Full up sequence with wrap
      step(0, 1, 3'b000); check("seq0_first", 3'd0, 1, 0, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b001); check("seq1", 3'd1, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b011); check("seq2", 3'd2, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b010); check("seq3", 3'd3, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b110); check("seq4", 3'd4, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b111); check("seq5", 3'd5, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b101); check("seq6", 3'd6, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b100); check("seq7", 3'd7, 1, 1, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b000); check("seq_wrap", 3'd0, 1, 1, 0, 1, 0, 8'd1, 8'd0);

      // Down step and hold
      step(0, 1, 3'b001); check("up_to1", 3'd1, 1, 1, 0, 0, 0, 8'd1, 8'd0);
      step(0, 1, 3'b011); check("up_to2", 3'd2, 1, 1, 0, 0, 0, 8'd1, 8'd0);
      step(0, 1, 3'b001); check("down", 3'd1, 1, 0, 1, 0, 0, 8'd1, 8'd0);
      step(0, 1, 3'b001); check("hold", 3'd1, 1, 0, 0, 0, 0, 8'd1, 8'd0);

      // Illegal step, recovery, then up
      step(0, 1, 3'b110); check("err", 3'd4, 0, 0, 0, 0, 1, 8'd1, 8'd1);
      step(0, 1, 3'b110); check("relock", 3'd4, 1, 0, 0, 0, 0, 8'd1, 8'd1);
      step(0, 1, 3'b111); check("up_after", 3'd5, 1, 1, 0, 0, 0, 8'd1, 8'd1);

      // Alternating enable; gray changes on disabled cycles are ignored
      step(0, 1, 3'b101); check("alt_on6", 3'd6, 1, 1, 0, 0, 0, 8'd1, 8'd1);
      step(0, 0, 3'b000); check("alt_off6", 3'd6, 1, 0, 0, 0, 0, 8'd1, 8'd1);
      step(0, 1, 3'b100); check("alt_on7", 3'd7, 1, 1, 0, 0, 0, 8'd1, 8'd1);
      step(0, 0, 3'b011); check("alt_off7", 3'd7, 1, 0, 0, 0, 0, 8'd1, 8'd1);
      step(0, 1, 3'b000); check("alt_wrap", 3'd0, 1, 1, 0, 1, 0, 8'd2, 8'd1);
      step(0, 0, 3'b111); check("alt_offw", 3'd0, 1, 0, 0, 0, 0, 8'd2, 8'd1);

      // Third wrap, then second error to land in ERROR
      step(0, 1, 3'b001);
      step(0, 1, 3'b011);
      step(0, 1, 3'b010);
      step(0, 1, 3'b110);
      step(0, 1, 3'b111);
      step(0, 1, 3'b101);
      step(0, 1, 3'b100);
      step(0, 1, 3'b000); check("wrap3", 3'd0, 1, 1, 0, 1, 0, 8'd3, 8'd1);
      step(0, 1, 3'b110); check("err2", 3'd4, 0, 0, 0, 0, 1, 8'd3, 8'd2);

      // Reset in ERROR discards the sample on the reset edge
      step(1, 1, 3'b011); check("rst_error", 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
      step(0, 1, 3'b010); check("post_rst", 3'd3, 1, 0, 0, 0, 0, 8'd0, 8'd0);

      // 260 illegal steps: err_cnt saturates, wrap_cnt untouched
      for (int k = 0; k < 260; k++) begin
         step(0, 1, 3'b000);
         if (k == 0)   check("sat_first", 3'd0, 0, 0, 0, 0, 1, 8'd0, 8'd1);
         if (k == 254) check("sat_255", 3'd0, 0, 0, 0, 0, 1, 8'd0, 8'd255);
         if (k == 259) check("sat_hold", 3'd0, 0, 0, 0, 0, 1, 8'd0, 8'd255);
         step(0, 1, 3'b110);
      end
      check("sat_relock", 3'd4, 1, 0, 0, 0, 0, 8'd0, 8'd255);
      step(0, 1, 3'b111); check("sat_up", 3'd5, 1, 1, 0, 0, 0, 8'd0, 8'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
